// File: rtl/pc_sequencer.sv
// pc_sequencer -- program-counter unit for the CPU fetch stage.
//
// Holds the current fetch address and picks the next one from, highest
// priority first: branch, call, jump, return, sequential (pc + STEP).
// Every loaded target has its low log2(STEP) bits cleared.
// All state advances only while pc_write_i is high, so hazard logic can
// stall fetch.
//
// Optional feature macro: PC_SEQUENCER_RAS_EN
//   defined   : a RAS_DEPTH-entry circular return-address stack is built.
//               A call pushes pc + STEP and a return pops it.
//   undefined : no stack is built. A call acts as a plain jump and a
//               return is ignored. The RAS status outputs read 0.
//
// Ports:
//   clk_i            clock; all state updates on the rising edge
//   rst_n            synchronous active-low reset
//   pc_write_i       update enable (0 holds every piece of state)
//   branch_i         branch redirect request, target branch_target_i
//   jump_i / call_i  jump / call request, target jump_target_i
//   ret_i            return request (pop)
//   pc_o             current PC (registered)
//   pc_plus_o        pc_o + STEP modulo 2^WIDTH (combinational)
//   ras_count_o      number of valid stack entries
//   ras_ovf_o        sticky: a push dropped the oldest entry
//   ras_unf_o        sticky: a pop found the stack empty
module pc_sequencer #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = {WIDTH{1'b0}},
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  input  logic                       pc_write_i,
  input  logic                       branch_i,
  input  logic [WIDTH-1:0]           branch_target_i,
  input  logic                       jump_i,
  input  logic                       call_i,
  input  logic [WIDTH-1:0]           jump_target_i,
  input  logic                       ret_i,
  output logic [WIDTH-1:0]           pc_o,
  output logic [WIDTH-1:0]           pc_plus_o,
  output logic [$clog2(RAS_DEPTH):0] ras_count_o,
  output logic                       ras_ovf_o,
  output logic                       ras_unf_o
);

  // STEP is a power of two, so STEP-1 is exactly the set of low bits to clear.
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(STEP - 32'd1));

  function automatic logic [WIDTH-1:0] align_addr(input logic [WIDTH-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pc_plus_s;
  logic [WIDTH-1:0] pc_next_s;

  assign pc_plus_s = pc_r + WIDTH'(STEP);
  assign pc_o      = pc_r;
  assign pc_plus_o = pc_plus_s;

`ifdef PC_SEQUENCER_RAS_EN
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  // ras_ptr_r names the next free slot. The top entry is at ras_ptr_r - 1.
  // When the stack is full, the next free slot holds the oldest entry, so a
  // push there overwrites the oldest entry.
  logic [WIDTH-1:0] ras_mem_r [RAS_DEPTH];
  logic [PW-1:0]    ras_ptr_r;
  logic [CW-1:0]    ras_count_r;
  logic             ras_ovf_r;
  logic             ras_unf_r;
  logic [PW-1:0]    ras_top_idx_s;
  logic             ras_full_s;
  logic             ras_empty_s;
  logic             push_s;
  logic             pop_s;
  logic             unf_hit_s;

  assign ras_top_idx_s = ras_ptr_r - PW'(1);
  assign ras_full_s    = (ras_count_r == CW'(RAS_DEPTH));
  assign ras_empty_s   = (ras_count_r == CW'(0));
  assign ras_count_o   = ras_count_r;
  assign ras_ovf_o     = ras_ovf_r;
  assign ras_unf_o     = ras_unf_r;
`else
  // Return requests have no effect without a stack.
  logic ras_unused_s;
  assign ras_unused_s = ret_i;
  assign ras_count_o  = {($clog2(RAS_DEPTH) + 1){1'b0}};
  assign ras_ovf_o    = 1'b0;
  assign ras_unf_o    = 1'b0;
`endif

  // Next-PC priority select and stack operation decode.
  always_comb begin
    pc_next_s = pc_plus_s;
`ifdef PC_SEQUENCER_RAS_EN
    push_s    = 1'b0;
    pop_s     = 1'b0;
    unf_hit_s = 1'b0;
`endif
    if (branch_i) begin
      pc_next_s = align_addr(branch_target_i);
    end else if (call_i) begin
      pc_next_s = align_addr(jump_target_i);
`ifdef PC_SEQUENCER_RAS_EN
      push_s    = 1'b1;
`endif
    end else if (jump_i) begin
      pc_next_s = align_addr(jump_target_i);
`ifdef PC_SEQUENCER_RAS_EN
    end else if (ret_i) begin
      if (!ras_empty_s) begin
        pc_next_s = align_addr(ras_mem_r[ras_top_idx_s]);
        pop_s     = 1'b1;
      end else begin
        // An empty stack falls through to the sequential address.
        pc_next_s = pc_plus_s;
        unf_hit_s = 1'b1;
      end
`endif
    end else begin
      pc_next_s = pc_plus_s;
    end
  end

  // PC register.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      pc_r <= align_addr(RESET_VEC);
    end else if (pc_write_i) begin
      pc_r <= pc_next_s;
    end
  end

`ifdef PC_SEQUENCER_RAS_EN
  // Stack pointer, count and sticky flags.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      ras_ptr_r   <= {PW{1'b0}};
      ras_count_r <= {CW{1'b0}};
      ras_ovf_r   <= 1'b0;
      ras_unf_r   <= 1'b0;
    end else if (pc_write_i) begin
      if (push_s) begin
        ras_ptr_r <= ras_ptr_r + PW'(1);
        if (ras_full_s) begin
          ras_ovf_r <= 1'b1;
        end else begin
          ras_count_r <= ras_count_r + CW'(1);
        end
      end else if (pop_s) begin
        ras_ptr_r   <= ras_top_idx_s;
        ras_count_r <= ras_count_r - CW'(1);
      end else if (unf_hit_s) begin
        ras_unf_r <= 1'b1;
      end
    end
  end

  // Stack storage. It has no reset because entries past the count are never read.
  always_ff @(posedge clk_i) begin
    if (rst_n && pc_write_i && push_s) begin
      ras_mem_r[ras_ptr_r] <= pc_plus_s;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (WIDTH=16, STEP=4, RAS_DEPTH=4).
// A behavioural model produces the expected state for each driven cycle and
// pushes it to a scoreboard. The entry is popped and compared after the edge.
// Expectations follow PC_SEQUENCER_RAS_EN, so the bench covers either build.
module tb_pc_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_write_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [15:0] branch_target_i = 16'h0000;
  logic        jump_i = 1'b0;
  logic        call_i = 1'b0;
  logic [15:0] jump_target_i = 16'h0000;
  logic        ret_i = 1'b0;
  logic [15:0] pc_o;
  logic [15:0] pc_plus_o;
  logic [2:0]  ras_count_o;
  logic        ras_ovf_o;
  logic        ras_unf_o;

  pc_sequencer #(.WIDTH(16), .STEP(4), .RESET_VEC(16'h0000), .RAS_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .pc_write_i(pc_write_i),
    .branch_i(branch_i), .branch_target_i(branch_target_i),
    .jump_i(jump_i), .call_i(call_i), .jump_target_i(jump_target_i),
    .ret_i(ret_i), .pc_o(pc_o), .pc_plus_o(pc_plus_o),
    .ras_count_o(ras_count_o), .ras_ovf_o(ras_ovf_o), .ras_unf_o(ras_unf_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [15:0] pc;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_ras[$];
  logic [15:0] m_pc;
  logic        m_ovf;
  logic        m_unf;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge, using the inputs currently driven.
  task automatic model_step();
    if (!rst_n) begin
      m_pc = 16'h0000; m_ras.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (pc_write_i) begin
      if (branch_i) begin
        m_pc = branch_target_i & 16'hFFFC;
      end else if (call_i) begin
`ifdef PC_SEQUENCER_RAS_EN
        m_ras.push_back(m_pc + 16'd4);
        if (m_ras.size() > 4) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
`endif
        m_pc = jump_target_i & 16'hFFFC;
      end else if (jump_i) begin
        m_pc = jump_target_i & 16'hFFFC;
      end else if (ret_i) begin
`ifdef PC_SEQUENCER_RAS_EN
        if (m_ras.size() > 0) begin
          m_pc = m_ras.pop_back();
        end else begin
          m_pc  = m_pc + 16'd4;
          m_unf = 1'b1;
        end
`else
        m_pc = m_pc + 16'd4;
`endif
      end else begin
        m_pc = m_pc + 16'd4;
      end
    end
  endtask

  // Drive one cycle, record the expected state, and compare it after the edge.
  task automatic cyc(input logic rst, input logic we, input logic br, input logic [15:0] bt,
                     input logic jmp, input logic cl, input logic [15:0] jt, input logic rt);
    exp_t e;
    rst_n = rst; pc_write_i = we; branch_i = br; branch_target_i = bt;
    jump_i = jmp; call_i = cl; jump_target_i = jt; ret_i = rt;
    model_step();
    e.pc = m_pc; e.cnt = 3'(m_ras.size()); e.ovf = m_ovf; e.unf = m_unf;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val("pc_o", {16'h0000, pc_o}, {16'h0000, e.pc});
      check_val("pc_plus_o", {16'h0000, pc_plus_o}, {16'h0000, e.pc + 16'd4});
      check_val("ras_count_o", {29'd0, ras_count_o}, {29'd0, e.cnt});
      check_val("ras_ovf_o", {31'd0, ras_ovf_o}, {31'd0, e.ovf});
      check_val("ras_unf_o", {31'd0, ras_unf_o}, {31'd0, e.unf});
    end
  endtask

  task automatic idle(input logic we);
    cyc(1'b1, we, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
  endtask
  task automatic do_jump(input logic [15:0] t);
    cyc(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, t, 1'b0);
  endtask
  task automatic do_call(input logic [15:0] t);
    cyc(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, t, 1'b0);
  endtask
  task automatic do_ret();
    cyc(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
  endtask
  task automatic do_reset();
    cyc(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    m_pc = 16'h0000; m_ovf = 1'b0; m_unf = 1'b0;

    // Reset, sequential run, then a stall.
    do_reset();
    for (int i = 0; i < 3; i++) idle(1'b1);
    idle(1'b0);
    idle(1'b0);

    // Wrap at the top of the address space, then an unaligned branch target.
    do_jump(16'hFFFC);
    idle(1'b1);
    cyc(1'b1, 1'b1, 1'b1, 16'h1237, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Call immediately followed by return.
    do_jump(16'h0100);
    do_call(16'h2000);
    do_ret();

    // Overflow on the fifth call, four returns, then underflow.
    do_jump(16'h0000);
    for (int i = 1; i <= 5; i++) do_call(16'(i * 16'h1000));
    for (int i = 0; i < 5; i++) do_ret();

    // Simultaneous requests. The branch wins and nothing is pushed.
    do_call(16'h3000);
    cyc(1'b1, 1'b1, 1'b1, 16'h0800, 1'b0, 1'b1, 16'h2000, 1'b1);
    // A jump beats a return.
    cyc(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0A00, 1'b1);
    // A return held across stalled cycles pops only once.
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    do_ret();
    // Reset during a stalled call discards the stack and the flags.
    do_call(16'h4000);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h5000, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h5000, 1'b0);
    do_ret();

    // Random traffic. Calls and returns are weighted so the stack moves.
    for (int i = 0; i < 200; i++) begin
      automatic int unsigned r = $urandom_range(0, 99);
      cyc((r != 0), ($urandom_range(0, 4) != 0), (r >= 90), 16'($urandom),
          (r >= 80 && r < 90), (r >= 40 && r < 80), 16'($urandom),
          (r >= 10 && r < 60));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter unit for the CPU fetch stage. Holds the current fetch address and selects the next one from sequential increment, branch redirect, jump, call or return. An optional return-address stack (RAS) supplies return targets. All state updates are gated by a write enable so hazard logic can stall fetch.

## Interface

Parameters:
- `WIDTH`, 16, PC width in bits.
- `STEP`, 4, sequential increment in bytes. Must be a power of two, at least 1.
- `RESET_VEC`, 0, value loaded into the PC on reset.
- `RAS_DEPTH`, 4, RAS entries. Must be a power of two, at least 2.

Ports:
- `clk_i`, in, 1: clock. All state updates on the rising edge.
- `rst_n`, in, 1: reset. Synchronous, active-low.
- `pc_write_i`, in, 1: update enable. 0 holds all state.
- `branch_i`, in, 1: branch redirect request.
- `branch_target_i`, in, WIDTH: branch target.
- `jump_i`, in, 1: unconditional jump request.
- `call_i`, in, 1: call request (jump plus push).
- `jump_target_i`, in, WIDTH: target for `jump_i` and `call_i`.
- `ret_i`, in, 1: return request (pop).
- `pc_o`, out, WIDTH: current PC, registered.
- `pc_plus_o`, out, WIDTH: `pc_o + STEP` modulo 2^WIDTH, combinational.
- `ras_count_o`, out, clog2(RAS_DEPTH)+1: number of valid RAS entries.
- `ras_ovf_o`, out, 1: sticky flag, set when a push drops an entry.
- `ras_unf_o`, out, 1: sticky flag, set when a pop finds the RAS empty.

## Operation

- Next-PC priority, highest first: `branch_i`, then `call_i`, then `jump_i`, then `ret_i`, then sequential (`pc_o + STEP`).
- Target alignment: the low log2(STEP) bits of every loaded target are forced to 0.
- Arithmetic is unsigned modulo 2^WIDTH. When `pc_o` = 2^WIDTH − STEP, the sequential next PC is 0.
- The RAS is a circular buffer with a top pointer and a count.
- Call (selected, `pc_write_i` = 1):
  - Pushes `pc_plus_o` onto the RAS.
  - If the count is already RAS_DEPTH, the oldest entry is overwritten, the count stays at RAS_DEPTH and `ras_ovf_o` is set.
- Return (selected):
  - If count > 0: next PC is the top entry, the entry is popped and the count decrements.
  - If count = 0: next PC is `pc_plus_o`, the count stays 0 and `ras_unf_o` is set.
- Lower-priority requests are ignored when a higher one is selected. For example, `branch_i` together with `call_i` loads the branch target and does not push.
- `pc_write_i` = 0 holds `pc_o`, the RAS contents, the pointer, the count and both flags, whatever the other inputs are.
- Reset values:
  - `pc_o` = RESET_VEC (aligned).
  - `ras_count_o` = 0, `ras_ovf_o` = 0, `ras_unf_o` = 0.
  - RAS pointer = 0. RAS entry contents are don't-care.
- Reset takes precedence over `pc_write_i` and all requests.
- Reset asserted mid-sequence discards all pending RAS state.
- The sticky flags clear only on reset.

## Timing

- Single-cycle latency. Requests sampled at edge N appear on `pc_o` and `ras_count_o` after edge N.
- `pc_plus_o` follows `pc_o` in the same cycle.
- No handshake: every request is single-cycle and level-sampled only while `pc_write_i` = 1. A request held across stalled cycles takes effect once, on the first enabled edge.
- Flags assert in the same cycle as the offending push or pop.
- Back-to-back call followed by return returns to the address pushed one cycle earlier. No bypass bubble is allowed.

## Configuration

- `PC_SEQUENCER_RAS_EN` defined: the RAS is built and behaves as described above.
- `PC_SEQUENCER_RAS_EN` undefined:
  - No RAS storage is built.
  - `call_i` behaves exactly as `jump_i`.
  - `ret_i` is ignored, so the next PC falls through to sequential.
  - `ras_count_o`, `ras_ovf_o` and `ras_unf_o` are tied to 0.
  - The port list is unchanged.

## Test plan

Defaults are WIDTH=16, STEP=4, RESET_VEC=0 and RAS_DEPTH=4 unless stated. All scenarios have `PC_SEQUENCER_RAS_EN` defined except scenario 6.

1. Reset, then 3 enabled idle cycles: `pc_o` reads 0x0000, 0x0004, 0x0008, 0x000C. `pc_write_i`=0 for 2 cycles holds 0x000C.
2. With `pc_o`=0xFFFC, one idle cycle: `pc_o`=0x0000. Then `branch_i` with target 0x1237: `pc_o`=0x1234.
3. At `pc_o`=0x0100, `call_i` to 0x2000, then `ret_i`: `pc_o` goes 0x2000 then 0x0104, and `ras_count_o` goes 1 then 0.
4. Five calls from 0x0000, 0x1000, 0x2000, 0x3000, 0x4000:
   - After the fifth call, `ras_ovf_o`=1 and `ras_count_o`=4.
   - Four returns yield 0x4004, 0x3004, 0x2004, 0x1004.
   - A fifth return yields `pc_plus_o` and sets `ras_unf_o`=1.
5. Simultaneous requests:
   - `branch_i` + `call_i` + `ret_i` with branch target 0x0800: `pc_o`=0x0800 and the count is unchanged.
   - Reset asserted during a stalled call: `pc_o`=0, count 0, flags 0.
6. With `PC_SEQUENCER_RAS_EN` undefined: `call_i` to 0x2000 gives `pc_o`=0x2000 and count 0. A following `ret_i` gives 0x2004.
